crosswalk: RTL and testbench



---
 rtl/crosswalk_pkg.sv | 55 +++++
 rtl/crosswalk_timer.sv | 37 +++
 rtl/crosswalk.sv | 124 ++++++++++++
 tb/tb_crosswalk.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/crosswalk_pkg.sv
// Shared definitions for the pedestrian-crossing controller: phase timings,
// timer width, state encoding and the lamp pattern shown in each state.
// Lamp vectors are ordered {RR, RY, RG, PR, PG}.
package crosswalk_pkg;

  localparam int GREEN_MIN_CYC = 10;
  localparam int YELLOW_CYC    = 5;
  localparam int CLEAR_CYC     = 2;
  localparam int WALK_CYC      = 20;
  localparam int FLASH_CYC     = 6;

  localparam int MAX_DUR_A = (GREEN_MIN_CYC > YELLOW_CYC) ? GREEN_MIN_CYC : YELLOW_CYC;
  localparam int MAX_DUR_B = (CLEAR_CYC > WALK_CYC) ? CLEAR_CYC : WALK_CYC;
  localparam int MAX_DUR   = (MAX_DUR_A > MAX_DUR_B) ? MAX_DUR_A : MAX_DUR_B;
  localparam int TIMER_W   = $clog2(MAX_DUR) + 1;

  typedef logic [TIMER_W-1:0] timer_t;

  // Timer reload values: a timed state lasts exactly its duration because it
  // leaves on the cycle the down-counter reads zero.
  localparam timer_t GREEN_MIN_T   = timer_t'(GREEN_MIN_CYC);
  localparam timer_t YELLOW_LOAD_T = timer_t'(YELLOW_CYC - 1);
  localparam timer_t CLEAR_LOAD_T  = timer_t'(CLEAR_CYC - 1);
  localparam timer_t WALK_LOAD_T   = timer_t'(WALK_CYC - 1);
  localparam timer_t FLASH_T       = timer_t'(FLASH_CYC);

  typedef enum logic [2:0] {
    ROAD_GREEN,
    ROAD_YELLOW,
    CLEAR_IN,
    PED_WALK,
    CLEAR_OUT
  } state_e;

  localparam int LAMP_RR = 4;
  localparam int LAMP_RY = 3;
  localparam int LAMP_RG = 2;
  localparam int LAMP_PR = 1;
  localparam int LAMP_PG = 0;

  localparam logic [4:0] LAMPS_GREEN  = 5'b00110;
  localparam logic [4:0] LAMPS_YELLOW = 5'b01010;
  localparam logic [4:0] LAMPS_CLEAR  = 5'b10010;
  localparam logic [4:0] LAMPS_WALK   = 5'b10001;

  function automatic logic [4:0] lamps_of(input state_e s);
    case (s)
      ROAD_GREEN:  return LAMPS_GREEN;
      ROAD_YELLOW: return LAMPS_YELLOW;
      PED_WALK:    return LAMPS_WALK;
      default:     return LAMPS_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/crosswalk_timer.sv
// Phase timer: loadable counter that can count down (timed phases) or up
// (green dwell count), with a zero flag used as the phase-done indication.
module crosswalk_timer #(
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: load has priority, then down-count, then up-count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (load)      count_d = load_val;
    else if (dec)  count_d = count_q - WIDTH'(1);
    else if (inc)  count_d = count_q + WIDTH'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/crosswalk.sv
// Pedestrian-crossing controller top: road rests on green; a latched pedestrian
// request runs yellow -> all-red -> walk -> all-red -> green. Lamps are registered
// and always reflect the current state.
// Optional build macro PED_FLASH_EN: pedestrian green flashes (starting dark)
// during the last FLASH_CYC cycles of the walk phase.
module crosswalk
  import crosswalk_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic BUTTON,
  input  logic SENSOR,
  output logic PR,
  output logic PG,
  output logic RR,
  output logic RG,
  output logic RY
);

  state_e     state_q, state_d;
  logic       req_q, req_d;
  logic [4:0] lamps_q, lamps_d;

  logic   tmr_load, tmr_dec, tmr_inc, tmr_zero;
  timer_t tmr_load_val, tmr_count;

  crosswalk_timer #(.WIDTH(TIMER_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .inc      (tmr_inc),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Next-state and timer control; green counts up, timed phases count down.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    tmr_inc      = 1'b0;
    case (state_q)
      ROAD_GREEN: begin
        if ((req_q || BUTTON) && ((tmr_count >= GREEN_MIN_T) || !SENSOR)) begin
          state_d      = ROAD_YELLOW;
          tmr_load     = 1'b1;
          tmr_load_val = YELLOW_LOAD_T;
        end else begin
          tmr_inc = (tmr_count < GREEN_MIN_T);
        end
      end
      ROAD_YELLOW: begin
        if (tmr_zero) begin
          state_d      = CLEAR_IN;
          tmr_load     = 1'b1;
          tmr_load_val = CLEAR_LOAD_T;
        end else tmr_dec = 1'b1;
      end
      CLEAR_IN: begin
        if (tmr_zero) begin
          state_d      = PED_WALK;
          tmr_load     = 1'b1;
          tmr_load_val = WALK_LOAD_T;
        end else tmr_dec = 1'b1;
      end
      PED_WALK: begin
        if (tmr_zero) begin
          state_d      = CLEAR_OUT;
          tmr_load     = 1'b1;
          tmr_load_val = CLEAR_LOAD_T;
        end else tmr_dec = 1'b1;
      end
      CLEAR_OUT: begin
        if (tmr_zero) begin
          state_d      = ROAD_GREEN;
          tmr_load     = 1'b1;
          tmr_load_val = '0;
        end else tmr_dec = 1'b1;
      end
      default: state_d = ROAD_GREEN;
    endcase
  end

  // Request latch: any press outside the walk phase is remembered; walk entry serves it.
  always_comb begin
    req_d = req_q;
    if (state_q != PED_WALK && BUTTON)                req_d = 1'b1;
    if (state_q != PED_WALK && state_d == PED_WALK)   req_d = 1'b0;
  end

  // Lamp pattern for the next cycle, including the optional walk-tail flash.
  always_comb begin
    lamps_d = lamps_of(state_d);
`ifdef PED_FLASH_EN
    // Next cycle is inside the flash window when the timer will read below FLASH_CYC.
    if (state_q == PED_WALK && !tmr_zero && tmr_count <= FLASH_T) begin
      lamps_d[LAMP_PG] = (tmr_count == FLASH_T) ? 1'b0 : ~lamps_q[LAMP_PG];
    end
`endif
  end

  // State, request and lamp registers; reset forces road green / ped red.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ROAD_GREEN;
      req_q   <= 1'b0;
      lamps_q <= LAMPS_GREEN;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      lamps_q <= lamps_d;
    end
  end

  assign RR = lamps_q[LAMP_RR];
  assign RY = lamps_q[LAMP_RY];
  assign RG = lamps_q[LAMP_RG];
  assign PR = lamps_q[LAMP_PR];
  assign PG = lamps_q[LAMP_PG];

endmodule

// File: tb/tb_crosswalk.sv
// Self-checking bench for crosswalk: a phase/elapsed-cycle reference model is
// compared against the lamps every cycle, with directed scenarios carrying
// hand-computed lamp expectations. Lamp vectors are {RR,RY,RG,PR,PG}.
module tb_crosswalk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic sensor = 1'b1;
  logic pr, pg, rr, rg, ry;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  crosswalk dut (
    .CLK    (clk),
    .RST    (rst),
    .BUTTON (button),
    .SENSOR (sensor),
    .PR     (pr),
    .PG     (pg),
    .RR     (rr),
    .RG     (rg),
    .RY     (ry)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..4 (green, yellow, clear-in, walk, clear-out),
  // cycles elapsed in the phase, and the pending-request flag.
  typedef struct {
    int phase;
    int elapsed;
    bit req;
  } model_t;

  model_t m = '{phase: 0, elapsed: 0, req: 1'b0};

  function automatic int dur_of(input int phase);
    case (phase)
      1:       return 5;
      3:       return 20;
      default: return 2;
    endcase
  endfunction

  function automatic model_t model_next(input model_t cur, input bit r, input bit b, input bit s);
    model_t nx;
    bit leave;
    nx = cur;
    if (r) begin
      nx.phase = 0;
      nx.elapsed = 0;
      nx.req = 1'b0;
      return nx;
    end
    if (cur.phase == 0) leave = (cur.req || b) && (cur.elapsed >= 10 || !s);
    else                leave = (cur.elapsed == dur_of(cur.phase) - 1);
    if (cur.phase != 3 && b) nx.req = 1'b1;
    if (leave) begin
      nx.phase = (cur.phase + 1) % 5;
      nx.elapsed = 0;
      if (nx.phase == 3) nx.req = 1'b0;
    end else begin
      nx.elapsed = cur.elapsed + 1;
    end
    return nx;
  endfunction

  function automatic logic [4:0] model_lamps(input model_t cur);
    int k;
    case (cur.phase)
      0: return 5'b00110;
      1: return 5'b01010;
      3: begin
`ifdef PED_FLASH_EN
        k = cur.elapsed - (20 - 6);
        if (k >= 0) return {4'b1000, 1'(k % 2)};
`endif
        return 5'b10001;
      end
      default: return 5'b10010;
    endcase
  endfunction

  always @(posedge clk) m <= model_next(m, rst, button, sensor);

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus lamp invariants.
  always @(negedge clk) begin
    if (started) begin
      check("lamps_vs_model", {rr, ry, rg, pr, pg}, model_lamps(m));
      check("road_onehot", {4'b0, $onehot({rr, ry, rg})}, 5'b00001);
      check("pg_needs_rr", {4'b0, pg & ~rr}, 5'b00000);
`ifdef PED_FLASH_EN
      check("ped_not_both", {4'b0, pr & pg}, 5'b00000);
`else
      check("ped_onehot", {4'b0, pr ^ pg}, 5'b00001);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Hold reset three cycles checking the reset lamps; afterwards we sit in cycle k=0.
  task automatic do_reset();
    rst = 1'b1;
    button = 1'b0;
    repeat (3) begin
      cyc();
      started = 1'b1;
      check("reset_lamps", {rr, ry, rg, pr, pg}, 5'b00110);
    end
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle: green holds for 100 cycles with no request.
    do_reset();
    for (int k = 0; k < 100; k++) begin
      sensor = 1'($urandom_range(0, 1));
      cyc();
    end
    check("idle_green", {rr, ry, rg, pr, pg}, 5'b00110);

    // Button held from cycle 25 for 50 cycles with traffic present.
    do_reset();
    sensor = 1'b1;
    for (int k = 0; k < 90; k++) begin
      button = (k >= 25 && k < 75);
      cyc();
      if (k + 1 == 25) check("held_green25", {rr, ry, rg, pr, pg}, 5'b00110);
      if (k + 1 == 26) check("held_yellow26", {rr, ry, rg, pr, pg}, 5'b01010);
      if (k + 1 == 33) check("held_walk33", {rr, ry, rg, pr, pg}, 5'b10001);
      if (k + 1 == 55) check("held_green55", {rr, ry, rg, pr, pg}, 5'b00110);
      if (k + 1 == 66) check("held_yellow66", {rr, ry, rg, pr, pg}, 5'b01010);
    end
    button = 1'b0;

    // Short pulse 3 cycles after reset with traffic: served once green count reaches 10.
    do_reset();
    sensor = 1'b1;
    for (int k = 0; k < 14; k++) begin
      button = (k == 3);
      cyc();
      if (k + 1 == 10) check("pulse_green10", {rr, ry, rg, pr, pg}, 5'b00110);
      if (k + 1 == 11) check("pulse_yellow11", {rr, ry, rg, pr, pg}, 5'b01010);
    end

    // No traffic: immediate service, full sequence, presses during walk ignored.
    do_reset();
    sensor = 1'b0;
    for (int k = 0; k < 61; k++) begin
      button = (k == 0) || (k == 10) || (k == 15) || (k == 27);
      cyc();
      if (k + 1 == 1)  check("nocar_yellow", {rr, ry, rg, pr, pg}, 5'b01010);
      if (k + 1 == 6)  check("nocar_clear_in", {rr, ry, rg, pr, pg}, 5'b10010);
      if (k + 1 == 8)  check("nocar_walk", {rr, ry, rg, pr, pg}, 5'b10001);
`ifdef PED_FLASH_EN
      if (k + 1 == 22) check("flash_first_dark", {rr, ry, rg, pr, pg}, 5'b10000);
      if (k + 1 == 23) check("flash_second_lit", {rr, ry, rg, pr, pg}, 5'b10001);
`else
      if (k + 1 == 22) check("walk_steady", {rr, ry, rg, pr, pg}, 5'b10001);
`endif
      if (k + 1 == 27) check("walk_last", {rr, ry, rg, pr, pg}, 5'b10001);
      if (k + 1 == 28) check("nocar_clear_out", {rr, ry, rg, pr, pg}, 5'b10010);
      if (k + 1 == 30) check("nocar_green", {rr, ry, rg, pr, pg}, 5'b00110);
      if (k + 1 == 60) check("nocar_green_holds", {rr, ry, rg, pr, pg}, 5'b00110);
    end

    // Reset in the middle of a walk phase returns to road green next cycle.
    do_reset();
    sensor = 1'b0;
    for (int k = 0; k < 15; k++) begin
      button = (k == 0);
      cyc();
    end
    check("mid_walk_before_rst", {rr, ry, rg, pr, pg}, 5'b10001);
    rst = 1'b1;
    button = 1'b1;
    cyc();
    check("rst_wins", {rr, ry, rg, pr, pg}, 5'b00110);
    rst = 1'b0;
    button = 1'b0;
    sensor = 1'b1;
    repeat (20) cyc();
    check("req_dropped_by_rst", {rr, ry, rg, pr, pg}, 5'b00110);

    // Randomized traffic, requests and occasional resets against the model.
    for (int k = 0; k < 3000; k++) begin
      button = ($urandom_range(0, 24) == 0);
      if (k % 8 == 0) sensor = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
